window_gen_3x3: RTL

Streaming 3x3 neighbourhood generator for the car-detection pixel pipeline. It accepts raster-ordered pixels, holds the two previous lines in on-chip line RAM, and emits a full 3x3 window plus its centre coordinate every time a pixel completes a window. It sits directly upstream of the per-stage delay lines and the filter kernels. Side-band signals are aligned to its 1-cycle latency by a delay line of depth 1 in the parent.

---
 rtl/vision_pkg.sv | 15 +
 rtl/line_ram.sv | 18 +
 rtl/window_gen_3x3.sv | 93 +++++++++
 3 files changed

// File: rtl/vision_pkg.sv
// vision_pkg: shared coordinate type and 3x3 window element indices
// Index k addresses win[N*k +: N]; row-major, top-left oldest.
package vision_pkg;
    localparam int CW = 11;
    typedef logic [CW-1:0] coord_t;
    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;
endpackage

// File: rtl/line_ram.sv
// line_ram: one-line pixel buffer, asynchronous read and synchronous write
// on a shared address, so a same-cycle read returns the old contents.
module line_ram #(
    parameter int N     = 8,
    parameter int DEPTH = 640
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [N-1:0]             wdata_i,
    output logic [N-1:0]             rdata_o
);
    logic [N-1:0] mem_q [DEPTH];
    assign rdata_o = mem_q[addr_i];
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end
endmodule

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: streaming 3x3 neighbourhood generator over two line buffers.
// Each accepted pixel shifts in a new right column; outputs lag acceptance by one ce cycle.
module window_gen_3x3
    import vision_pkg::*;
#(
    parameter int N      = 8,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic           vsync,
    input  logic           de,
    input  logic [N-1:0]   pix,
    output logic [9*N-1:0] win,
    output logic           win_valid,
    output logic [CW-1:0]  cx,
    output logic [CW-1:0]  cy
);
    localparam int AW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    logic [AW-1:0] x_q, x_d, x_in;
    logic [YW-1:0] y_q, y_d, y_in;
    logic [N-1:0]  w_q [9];
    logic [N-1:0]  w_d [9];
    logic          valid_q, valid_d;
    coord_t        cx_q, cx_d, cy_q, cy_d;
    logic [N-1:0]  a, b;
    logic          acc, last_x, last_y;
    line_ram #(.N(N), .DEPTH(WIDTH)) lb0 (
        .clk    (clk),
        .we_i   (acc),
        .addr_i (x_in),
        .wdata_i(pix),
        .rdata_o(b)
    );
    line_ram #(.N(N), .DEPTH(WIDTH)) lb1 (
        .clk    (clk),
        .we_i   (acc),
        .addr_i (x_in),
        .wdata_i(b),
        .rdata_o(a)
    );
    // vsync overrides the counters for the pixel arriving alongside it
    always_comb begin
        acc     = rst && ce && de;
        x_in    = vsync ? '0 : x_q;
        y_in    = vsync ? '0 : y_q;
        last_x  = x_in == AW'(WIDTH - 1);
        last_y  = y_in == YW'(HEIGHT - 1);
        x_d     = !de ? x_in : last_x ? '0 : x_in + 1'b1;
        y_d     = (!de || !last_x) ? y_in : last_y ? '0 : y_in + 1'b1;
        valid_d = de && x_in >= AW'(2) && y_in >= YW'(2);
        cx_d    = de ? CW'(x_in) - CW'(1) : cx_q;
        cy_d    = de ? CW'(y_in) - CW'(1) : cy_q;
        w_d     = w_q;
        if (de) begin
            w_d[WIN_TL] = w_q[WIN_TC];
            w_d[WIN_TC] = w_q[WIN_TR];
            w_d[WIN_TR] = a;
            w_d[WIN_ML] = w_q[WIN_MC];
            w_d[WIN_MC] = w_q[WIN_MR];
            w_d[WIN_MR] = b;
            w_d[WIN_BL] = w_q[WIN_BC];
            w_d[WIN_BC] = w_q[WIN_BR];
            w_d[WIN_BR] = pix;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
            for (int k = 0; k < 9; k++) w_q[k] <= '0;
        end else if (ce) begin
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            w_q     <= w_d;
        end
    end
    for (genvar i = 0; i < 9; i++) begin : g_win
        assign win[N*i +: N] = w_q[i];
    end
    assign win_valid = valid_q;
    assign cx        = cx_q;
    assign cy        = cy_q;
endmodule
